// File: rtl/sym_cn_rank_pp_pkg.sv
// Shared types and geometry helpers for the
// check-node LUT rank (banks, pages, loader).
package sym_cn_rank_pp_pkg;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } ld_state_t;

  function automatic int calc_ow(input int frames);
    return $clog2(frames);
  endfunction

  function automatic int calc_pw(
    input int entry_addr,
    input int frames
  );
    return entry_addr - $clog2(frames);
  endfunction

  function automatic int calc_bw(input int banks);
    return $clog2(banks);
  endfunction

  function automatic int calc_depth(
    input int entry_addr,
    input int frames
  );
    return 2 ** calc_pw(entry_addr, frames);
  endfunction

endpackage

// File: rtl/sym_cn_bank_mp.sv
// One LUT bank: a single write port and
// PORT_NUM independent registered read ports.
module sym_cn_bank_mp
  import sym_cn_rank_pp_pkg::*;
#(
  parameter int QUAN_SIZE = 3,
  parameter int ADDR_W    = 6,
  parameter int PORT_NUM  = 4
) (
  input  logic                          clk,
  input  logic                          wr_en,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [QUAN_SIZE-1:0]          wr_data,
  input  logic [PORT_NUM-1:0]           rd_en,
  input  logic [PORT_NUM*ADDR_W-1:0]    rd_addr,
  output logic [PORT_NUM*QUAN_SIZE-1:0] rd_data
);

  logic [QUAN_SIZE-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < PORT_NUM; p++) begin
      if (rd_en[p])
        rd_data[p*QUAN_SIZE +: QUAN_SIZE] <=
          mem[rd_addr[p*ADDR_W +: ADDR_W]];
    end
  end

endmodule

// File: rtl/sym_cn_rank_pp.sv
// Multi-port LUT rank with ping-pong frame pages
// and a streaming page loader.
module sym_cn_rank_pp
  import sym_cn_rank_pp_pkg::*;
#(
  parameter int QUAN_SIZE       = 3,
  parameter int ENTRY_ADDR      = 6,
  parameter int MULTI_FRAME_NUM = 2,
  parameter int BANK_NUM        = 2,
  parameter int PORT_NUM        = 4,
  localparam int PW = calc_pw(ENTRY_ADDR, MULTI_FRAME_NUM),
  localparam int OW = calc_ow(MULTI_FRAME_NUM),
  localparam int BW = calc_bw(BANK_NUM)
) (
  input  logic                          sys_clk,
  input  logic                          rst,
  input  logic [PORT_NUM-1:0]           rd_en,
  input  logic [PORT_NUM*BW-1:0]        rd_bank,
  input  logic [PORT_NUM*PW-1:0]        rd_page,
  input  logic [PORT_NUM*OW-1:0]        rd_offset,
  output logic [PORT_NUM*QUAN_SIZE-1:0] lut_data,
  output logic [PORT_NUM-1:0]           rd_valid,
  output logic [PORT_NUM-1:0]           rd_err,
  input  logic                          load_start,
  input  logic [OW-1:0]                 load_offset,
  input  logic [BANK_NUM*QUAN_SIZE-1:0] lut_in,
  input  logic                          lut_in_valid,
  output logic                          lut_in_ready,
  output logic                          load_busy,
  output logic                          load_done,
  output logic [MULTI_FRAME_NUM-1:0]    page_valid
);

  localparam int PAGE_DEPTH =
    calc_depth(ENTRY_ADDR, MULTI_FRAME_NUM);
  localparam int EA = ENTRY_ADDR;

  ld_state_t                   state;
  logic [OW-1:0]               off_q;
  logic [PW-1:0]               cnt;
  logic [MULTI_FRAME_NUM-1:0]  pv;
  logic                        wr_en;
  logic [EA-1:0]               wr_addr;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state <= LD_IDLE;
      off_q <= '0;
      cnt   <= '0;
      pv    <= '0;
    end else begin
      unique case (state)
        LD_IDLE: begin
          if (load_start) begin
            state            <= LD_LOAD;
            off_q            <= load_offset;
            cnt              <= '0;
            pv[load_offset]  <= 1'b0;
          end
        end
        LD_LOAD: begin
          if (lut_in_valid) begin
            // Last entry of the page: stop here, never spill into the next page.
            if (cnt == PW'(PAGE_DEPTH - 1)) begin
              state     <= LD_DONE;
              cnt       <= '0;
              pv[off_q] <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        LD_DONE: state <= LD_IDLE;
        default: state <= LD_IDLE;
      endcase
    end
  end

  assign lut_in_ready = (state == LD_LOAD);
  assign load_busy    = (state != LD_IDLE);
  assign load_done    = (state == LD_DONE);
  assign page_valid   = pv;
  assign wr_en        = lut_in_ready & lut_in_valid & ~rst;
  assign wr_addr      = {off_q, cnt};

  logic [PORT_NUM-1:0]     rd_go;
  logic [PORT_NUM-1:0]     hit;
  logic [PORT_NUM*EA-1:0]  rd_addr;

  assign rd_go = rd_en & {PORT_NUM{~rst}};

  always_comb begin
    hit     = '0;
    rd_addr = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      hit[p] = pv[rd_offset[p*OW +: OW]];
      rd_addr[p*EA +: EA] =
        {rd_offset[p*OW +: OW], rd_page[p*PW +: PW]};
    end
  end

  logic [PORT_NUM-1:0]    valid_q;
  logic [PORT_NUM-1:0]    err_q;
  logic [PORT_NUM-1:0]    zero_q;
  logic [PORT_NUM*BW-1:0] bank_q;

  // zero_q masks the output so an errored read holds 0 until the next read.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      valid_q <= '0;
      err_q   <= '0;
      zero_q  <= '1;
      bank_q  <= '0;
    end else begin
      valid_q <= rd_en;
      err_q   <= rd_en & ~hit;
      for (int p = 0; p < PORT_NUM; p++) begin
        if (rd_en[p]) begin
          zero_q[p]             <= ~hit[p];
          bank_q[p*BW +: BW]    <= rd_bank[p*BW +: BW];
        end
      end
    end
  end

  logic [PORT_NUM*QUAN_SIZE-1:0] bank_rd [BANK_NUM];

  for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
    sym_cn_bank_mp #(
      .QUAN_SIZE (QUAN_SIZE),
      .ADDR_W    (EA),
      .PORT_NUM  (PORT_NUM)
    ) u_bank (
      .clk     (sys_clk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (lut_in[b*QUAN_SIZE +: QUAN_SIZE]),
      .rd_en   (rd_go),
      .rd_addr (rd_addr),
      .rd_data (bank_rd[b])
    );
  end

  always_comb begin
    lut_data = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      if (!zero_q[p])
        lut_data[p*QUAN_SIZE +: QUAN_SIZE] =
          bank_rd[bank_q[p*BW +: BW]][p*QUAN_SIZE +: QUAN_SIZE];
    end
  end

  assign rd_valid = valid_q;
  assign rd_err   = err_q;

endmodule
